ddr3_avl_arbiter: RTL and testbench

Parametrised N-channel arbiter for the DDR3 Avalon-MM controller port. It replaces the fixed "read has priority over write" mux with round-robin arbitration across NUM_CH request channels, each of which may issue read or write bursts. A tag FIFO records the channel and burst length of each accepted read, so returning read data is routed back to the channel that issued it. Sits in the ddr3_clk domain between the frame reader/writer/CSR-test engines and the DDR3 controller.

---
 rtl/ddr3_avl_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_ddr3_avl_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_avl_arbiter.sv
// Round-robin N-channel arbiter in front of the DDR3 Avalon-MM controller port.
// Accepted reads are tagged with {channel, size} so returning beats are routed back.
module ddr3_avl_arbiter #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned ADDR_W    = 26,
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned SIZE_W    = 3,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned TAG_DEPTH = 8
) (
    input  logic                        ddr3_clk,
    input  logic                        reset_n,
    input  logic [NUM_CH-1:0]           ch_req,
    input  logic [NUM_CH-1:0]           ch_write,
    input  logic [NUM_CH*ADDR_W-1:0]    ch_addr,
    input  logic [NUM_CH*SIZE_W-1:0]    ch_size,
    input  logic [NUM_CH*DATA_W-1:0]    ch_wr_data,
    output logic [NUM_CH-1:0]           ch_ack,
    output logic [NUM_CH-1:0]           ch_rd_valid,
    output logic [DATA_W-1:0]           ch_rd_data,
    input  logic                        ddr3_avl_ready,
    output logic                        ddr3_avl_burstbegin,
    output logic [2:0]                  ddr3_avl_size,
    output logic                        ddr3_avl_read_req,
    output logic                        ddr3_avl_write_req,
    output logic [25:0]                 ddr3_avl_addr,
    output logic [DATA_W-1:0]           ddr3_avl_wr_data,
    input  logic                        ddr3_avl_read_data_valid,
    input  logic [DATA_W-1:0]           ddr3_avl_read_data,
    output logic [$clog2(TAG_DEPTH):0]  rd_outstanding,
    output logic                        err_unexpected_rd
);

    localparam int unsigned CH_W   = $clog2(NUM_CH);
    localparam int unsigned TAG_AW = $clog2(TAG_DEPTH);

    typedef enum logic [1:0] {StIdle, StRdCmd, StWrBurst} state_e;

    state_e              state_q;
    logic [CH_W-1:0]     rr_ptr_q;
    logic [CH_W-1:0]     grant_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [SIZE_W-1:0]   size_q;
    logic [SIZE_W-1:0]   beat_cnt_q;
    logic                read_req_q;
    logic                write_req_q;
    logic                burstbegin_q;

    logic [CH_W-1:0]     tag_ch_q   [TAG_DEPTH];
    logic [SIZE_W-1:0]   tag_size_q [TAG_DEPTH];
    logic [TAG_AW-1:0]   tag_wr_q;
    logic [TAG_AW-1:0]   tag_rd_q;
    logic [TAG_AW:0]     tag_cnt_q;
    logic [SIZE_W-1:0]   ret_cnt_q;
    logic [NUM_CH-1:0]   rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                err_q;

    logic [ADDR_W-1:0]   addr_arr  [NUM_CH];
    logic [SIZE_W-1:0]   size_arr  [NUM_CH];
    logic [DATA_W-1:0]   wdata_arr [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign addr_arr[i]  = ch_addr[i*ADDR_W +: ADDR_W];
        assign size_arr[i]  = ch_size[i*SIZE_W +: SIZE_W];
        assign wdata_arr[i] = ch_wr_data[i*DATA_W +: DATA_W];
    end

    // Size 0 means a single beat; oversize bursts are clamped to the legal maximum.
    function automatic logic [SIZE_W-1:0] clamp_size(input logic [SIZE_W-1:0] s);
        if (s == '0) begin
            return SIZE_W'(1);
        end else if (32'(s) > MAX_BURST) begin
            return SIZE_W'(MAX_BURST);
        end
        return s;
    endfunction

    logic tag_full;
    logic tag_empty;
    logic tag_push;
    logic tag_pop;
    logic rd_accept;
    logic last_beat;
    logic [CH_W-1:0] rr_next;

    assign tag_full  = (tag_cnt_q == (TAG_AW+1)'(TAG_DEPTH));
    assign tag_empty = (tag_cnt_q == '0);
    assign tag_push  = read_req_q & ddr3_avl_ready;
    assign rd_accept = ddr3_avl_read_data_valid & ~tag_empty;
    assign tag_pop   = rd_accept & (ret_cnt_q == tag_size_q[tag_rd_q] - SIZE_W'(1));
    assign last_beat = (beat_cnt_q == size_q - SIZE_W'(1));
    assign rr_next   = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + CH_W'(1);

    // First eligible channel at or above the RR pointer; reads wait while the tag FIFO is full.
    logic            arb_found;
    logic [CH_W-1:0] arb_pick;

    always_comb begin : arb
        logic [CH_W-1:0] idx;
        arb_found = 1'b0;
        arb_pick  = '0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = CH_W'((32'(rr_ptr_q) + k) % NUM_CH);
            if (!arb_found && ch_req[idx] && (ch_write[idx] || !tag_full)) begin
                arb_found = 1'b1;
                arb_pick  = idx;
            end
        end
    end

    always_ff @(posedge ddr3_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            addr_q       <= '0;
            size_q       <= '0;
            beat_cnt_q   <= '0;
            read_req_q   <= 1'b0;
            write_req_q  <= 1'b0;
            burstbegin_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arb_found) begin
                        grant_q      <= arb_pick;
                        addr_q       <= addr_arr[arb_pick];
                        size_q       <= clamp_size(size_arr[arb_pick]);
                        beat_cnt_q   <= '0;
                        burstbegin_q <= 1'b1;
                        if (ch_write[arb_pick]) begin
                            state_q     <= StWrBurst;
                            write_req_q <= 1'b1;
                        end else begin
                            state_q    <= StRdCmd;
                            read_req_q <= 1'b1;
                        end
                    end
                end
                StRdCmd: begin
                    if (ddr3_avl_ready) begin
                        read_req_q   <= 1'b0;
                        burstbegin_q <= 1'b0;
                        rr_ptr_q     <= rr_next;
                        state_q      <= StIdle;
                    end
                end
                StWrBurst: begin
                    if (ddr3_avl_ready) begin
                        burstbegin_q <= 1'b0;
                        if (last_beat) begin
                            write_req_q <= 1'b0;
                            beat_cnt_q  <= '0;
                            rr_ptr_q    <= rr_next;
                            state_q     <= StIdle;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + SIZE_W'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Tag FIFO and read-return routing run independently of the command FSM.
    always_ff @(posedge ddr3_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_ch_q[i]   <= '0;
                tag_size_q[i] <= '0;
            end
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            tag_cnt_q  <= '0;
            ret_cnt_q  <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            if (tag_push) begin
                tag_ch_q[tag_wr_q]   <= grant_q;
                tag_size_q[tag_wr_q] <= size_q;
                tag_wr_q             <= tag_wr_q + TAG_AW'(1);
            end
            if (rd_accept) begin
                ret_cnt_q <= tag_pop ? '0 : ret_cnt_q + SIZE_W'(1);
                rd_data_q <= ddr3_avl_read_data;
            end
            if (tag_pop) begin
                tag_rd_q <= tag_rd_q + TAG_AW'(1);
            end
            case ({tag_push, tag_pop})
                2'b10:   tag_cnt_q <= tag_cnt_q + (TAG_AW+1)'(1);
                2'b01:   tag_cnt_q <= tag_cnt_q - (TAG_AW+1)'(1);
                default: tag_cnt_q <= tag_cnt_q;
            endcase
            rd_valid_q <= rd_accept ? (NUM_CH'(1) << tag_ch_q[tag_rd_q]) : '0;
            if (ddr3_avl_read_data_valid && tag_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        ch_ack = '0;
        if ((read_req_q || write_req_q) && ddr3_avl_ready) begin
            ch_ack[grant_q] = 1'b1;
        end
    end

    logic [ADDR_W+25:0] addr_ext;
    logic [SIZE_W+2:0]  size_ext;

    assign addr_ext = {26'd0, addr_q};
    assign size_ext = {3'd0, size_q};

    assign ddr3_avl_addr       = addr_ext[25:0];
    assign ddr3_avl_size       = size_ext[2:0];
    assign ddr3_avl_read_req   = read_req_q;
    assign ddr3_avl_write_req  = write_req_q;
    assign ddr3_avl_burstbegin = burstbegin_q;
    // Gated so the bus reads zero outside a write burst.
    assign ddr3_avl_wr_data    = write_req_q ? wdata_arr[grant_q] : '0;
    assign ch_rd_valid         = rd_valid_q;
    assign ch_rd_data          = rd_data_q;
    assign rd_outstanding      = tag_cnt_q;
    assign err_unexpected_rd   = err_q;

endmodule

// File: tb/tb_ddr3_avl_arbiter.sv
// Directed self-checking bench for ddr3_avl_arbiter at its default parameters.
module tb_ddr3_avl_arbiter;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [3:0]    ch_req;
    logic [3:0]    ch_write;
    logic [103:0]  ch_addr;
    logic [11:0]   ch_size;
    logic [511:0]  ch_wr_data;
    logic [3:0]    ch_ack;
    logic [3:0]    ch_rd_valid;
    logic [127:0]  ch_rd_data;
    logic          ready;
    logic          burstbegin;
    logic [2:0]    avl_size;
    logic          read_req;
    logic          write_req;
    logic [25:0]   avl_addr;
    logic [127:0]  avl_wr_data;
    logic          rd_valid_in;
    logic [127:0]  rd_data_in;
    logic [3:0]    rd_outstanding;
    logic          err_rd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ddr3_avl_arbiter dut (
        .ddr3_clk                 (clk),
        .reset_n                  (rst_n),
        .ch_req                   (ch_req),
        .ch_write                 (ch_write),
        .ch_addr                  (ch_addr),
        .ch_size                  (ch_size),
        .ch_wr_data               (ch_wr_data),
        .ch_ack                   (ch_ack),
        .ch_rd_valid              (ch_rd_valid),
        .ch_rd_data               (ch_rd_data),
        .ddr3_avl_ready           (ready),
        .ddr3_avl_burstbegin      (burstbegin),
        .ddr3_avl_size            (avl_size),
        .ddr3_avl_read_req        (read_req),
        .ddr3_avl_write_req       (write_req),
        .ddr3_avl_addr            (avl_addr),
        .ddr3_avl_wr_data         (avl_wr_data),
        .ddr3_avl_read_data_valid (rd_valid_in),
        .ddr3_avl_read_data       (rd_data_in),
        .rd_outstanding           (rd_outstanding),
        .err_unexpected_rd        (err_rd)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input bit req, input bit wr, input logic [25:0] a,
                          input logic [2:0] sz, input logic [127:0] d);
        ch_req[ch]               = req;
        ch_write[ch]             = wr;
        ch_addr[ch*26 +: 26]     = a;
        ch_size[ch*3 +: 3]       = sz;
        ch_wr_data[ch*128 +: 128] = d;
    endtask

    task automatic clear_inputs();
        ch_req      = '0;
        ch_write    = '0;
        ch_addr     = '0;
        ch_size     = '0;
        ch_wr_data  = '0;
        ready       = 1'b1;
        rd_valid_in = 1'b0;
        rd_data_in  = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_ack(input int ch, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (ch_ack[ch]) seen = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        ch_req = 4'hF;
        #1 rst_n = 1'b0;
        #3;
        n_checks++; if (ch_ack !== 4'h0) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", ch_ack); end
        n_checks++; if (ch_rd_valid !== 4'h0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0000", ch_rd_valid); end
        n_checks++; if (ch_rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", ch_rd_data); end
        n_checks++; if (read_req !== 1'b0) begin n_fail++; $display("FAIL reset_read_req: got %b want 0", read_req); end
        n_checks++; if (write_req !== 1'b0) begin n_fail++; $display("FAIL reset_write_req: got %b want 0", write_req); end
        n_checks++; if (burstbegin !== 1'b0) begin n_fail++; $display("FAIL reset_burstbegin: got %b want 0", burstbegin); end
        n_checks++; if (avl_addr !== 26'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", avl_addr); end
        n_checks++; if (avl_size !== 3'd0) begin n_fail++; $display("FAIL reset_size: got %0d want 0", avl_size); end
        n_checks++; if (rd_outstanding !== 4'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d want 0", rd_outstanding); end
        n_checks++; if (err_rd !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_rd); end
    endtask

    task automatic test_single_read();
        logic [127:0] exp_d;
        do_reset();
        set_ch(1, 1'b1, 1'b0, 26'h100, 3'd4, '0);
        @(negedge clk);
        n_checks++; if (read_req !== 1'b0) begin n_fail++; $display("FAIL sr_grant_cycle: read_req %b want 0", read_req); end
        tick();
        @(negedge clk);
        n_checks++; if (read_req !== 1'b1) begin n_fail++; $display("FAIL sr_read_req: got %b want 1", read_req); end
        n_checks++; if (burstbegin !== 1'b1) begin n_fail++; $display("FAIL sr_burstbegin: got %b want 1", burstbegin); end
        n_checks++; if (avl_addr !== 26'h100) begin n_fail++; $display("FAIL sr_addr: got %h want 100", avl_addr); end
        n_checks++; if (avl_size !== 3'd4) begin n_fail++; $display("FAIL sr_size: got %0d want 4", avl_size); end
        n_checks++; if (ch_ack !== 4'b0010) begin n_fail++; $display("FAIL sr_ack: got %b want 0010", ch_ack); end
        tick();
        ch_req[1] = 1'b0;
        @(negedge clk);
        n_checks++; if (read_req !== 1'b0) begin n_fail++; $display("FAIL sr_req_drop: got %b want 0", read_req); end
        n_checks++; if (ch_ack !== 4'b0000) begin n_fail++; $display("FAIL sr_ack_pulse: got %b want 0000", ch_ack); end
        n_checks++; if (rd_outstanding !== 4'd1) begin n_fail++; $display("FAIL sr_outst1: got %0d want 1", rd_outstanding); end
        for (int i = 0; i <= 4; i++) begin
            tick();
            rd_valid_in = (i < 4);
            rd_data_in  = 128'hD0 + 128'(i);
            @(negedge clk);
            if (i == 0) begin
                n_checks++; if (ch_rd_valid !== 4'b0000) begin n_fail++; $display("FAIL sr_rv_early: got %b want 0000", ch_rd_valid); end
            end else begin
                exp_d = 128'hD0 + 128'(i - 1);
                n_checks++; if (ch_rd_valid !== 4'b0010) begin n_fail++; $display("FAIL sr_rv%0d: got %b want 0010", i - 1, ch_rd_valid); end
                n_checks++; if (ch_rd_data !== exp_d) begin n_fail++; $display("FAIL sr_rd%0d: got %h want %h", i - 1, ch_rd_data, exp_d); end
            end
            n_checks++;
            if (rd_outstanding !== ((i < 4) ? 4'd1 : 4'd0)) begin
                n_fail++; $display("FAIL sr_outst_beat%0d: got %0d want %0d", i, rd_outstanding, (i < 4) ? 1 : 0);
            end
        end
        tick();
        @(negedge clk);
        n_checks++; if (ch_rd_valid !== 4'b0000) begin n_fail++; $display("FAIL sr_rv_end: got %b want 0000", ch_rd_valid); end
    endtask

    task automatic test_round_robin();
        bit seen;
        logic [3:0] exp_ack;
        logic [25:0] exp_addr;
        do_reset();
        for (int i = 0; i < 4; i++) set_ch(i, 1'b1, 1'b0, 26'(32'h40 + i), 3'd1, '0);
        for (int k = 0; k < 5; k++) begin
            seen = 1'b0;
            for (int c = 0; c < 6 && !seen; c++) begin
                @(negedge clk);
                if (ch_ack != 4'b0) seen = 1'b1;
                else tick();
            end
            exp_ack  = 4'b0001 << (k % 4);
            exp_addr = 26'(32'h40 + (k % 4));
            n_checks++; if (ch_ack !== exp_ack) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", k, ch_ack, exp_ack); end
            n_checks++; if (avl_addr !== exp_addr) begin n_fail++; $display("FAIL rr_addr%0d: got %h want %h", k, avl_addr, exp_addr); end
            tick();
        end
        ch_req = '0;
    endtask

    task automatic test_write_backpressure();
        logic [5:0] pat;
        int b;
        int acks;
        logic [127:0] exp_w;
        do_reset();
        pat = 6'b111001;
        for (int i = 0; i < 4; i++) set_ch(i, 1'b0, 1'b1, 26'h3FF, 3'd2, 128'hBAD0 + 128'(i));
        set_ch(2, 1'b1, 1'b1, 26'h200, 3'd4, 128'hE0);
        b = 0;
        acks = 0;
        tick();
        for (int c = 0; c < 6; c++) begin
            ready = pat[c];
            exp_w = 128'hE0 + 128'(b);
            @(negedge clk);
            if (ch_ack[2]) acks++;
            n_checks++; if (write_req !== 1'b1) begin n_fail++; $display("FAIL wr_req_c%0d: got %b want 1", c, write_req); end
            n_checks++; if (burstbegin !== (b == 0)) begin n_fail++; $display("FAIL wr_bb_c%0d: got %b want %b", c, burstbegin, b == 0); end
            n_checks++; if (avl_wr_data !== exp_w) begin n_fail++; $display("FAIL wr_data_c%0d: got %h want %h", c, avl_wr_data, exp_w); end
            n_checks++; if (ch_ack !== (pat[c] ? 4'b0100 : 4'b0000)) begin n_fail++; $display("FAIL wr_ack_c%0d: got %b want %b", c, ch_ack, pat[c] ? 4'b0100 : 4'b0000); end
            n_checks++; if (avl_addr !== 26'h200) begin n_fail++; $display("FAIL wr_addr_c%0d: got %h want 200", c, avl_addr); end
            n_checks++; if (avl_size !== 3'd4) begin n_fail++; $display("FAIL wr_size_c%0d: got %0d want 4", c, avl_size); end
            tick();
            if (pat[c]) begin
                b++;
                if (b < 4) ch_wr_data[2*128 +: 128] = 128'hE0 + 128'(b);
                else ch_req[2] = 1'b0;
            end
        end
        ready = 1'b1;
        @(negedge clk);
        n_checks++; if (write_req !== 1'b0) begin n_fail++; $display("FAIL wr_done: write_req %b want 0", write_req); end
        n_checks++; if (acks !== 4) begin n_fail++; $display("FAIL wr_ack_count: got %0d want 4", acks); end
    endtask

    task automatic test_interleaved();
        bit seen;
        logic [127:0] exp_d;
        logic [3:0] exp_v;
        do_reset();
        set_ch(0, 1'b1, 1'b0, 26'h10, 3'd2, '0);
        set_ch(3, 1'b1, 1'b0, 26'h30, 3'd3, '0);
        wait_ack(0, 6, seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL il_ack0: no ack for ch0, ack %b", ch_ack); end
        tick();
        ch_req[0] = 1'b0;
        wait_ack(3, 6, seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL il_ack3: no ack for ch3, ack %b", ch_ack); end
        tick();
        ch_req[3] = 1'b0;
        @(negedge clk);
        n_checks++; if (rd_outstanding !== 4'd2) begin n_fail++; $display("FAIL il_outst: got %0d want 2", rd_outstanding); end
        for (int i = 0; i <= 5; i++) begin
            tick();
            rd_valid_in = (i < 5);
            rd_data_in  = 128'hA0 + 128'(i);
            @(negedge clk);
            if (i > 0) begin
                exp_d = 128'hA0 + 128'(i - 1);
                exp_v = (i - 1 < 2) ? 4'b0001 : 4'b1000;
                n_checks++; if (ch_rd_valid !== exp_v) begin n_fail++; $display("FAIL il_route%0d: got %b want %b", i - 1, ch_rd_valid, exp_v); end
                n_checks++; if (ch_rd_data !== exp_d) begin n_fail++; $display("FAIL il_data%0d: got %h want %h", i - 1, ch_rd_data, exp_d); end
            end
        end
        n_checks++; if (rd_outstanding !== 4'd0) begin n_fail++; $display("FAIL il_drain: got %0d want 0", rd_outstanding); end
    endtask

    task automatic test_tag_full();
        bit seen;
        int cnt;
        int a0;
        int a1;
        do_reset();
        set_ch(0, 1'b1, 1'b0, 26'h80, 3'd1, '0);
        cnt = 0;
        for (int c = 0; c < 40 && cnt < 8; c++) begin
            @(negedge clk);
            if (ch_ack[0]) cnt++;
            tick();
        end
        n_checks++; if (cnt !== 8) begin n_fail++; $display("FAIL tf_fill: got %0d acks want 8", cnt); end
        @(negedge clk);
        n_checks++; if (rd_outstanding !== 4'd8) begin n_fail++; $display("FAIL tf_outst8: got %0d want 8", rd_outstanding); end
        tick();
        set_ch(1, 1'b1, 1'b1, 26'h90, 3'd1, 128'h77);
        a0 = 0;
        a1 = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ch_ack[0]) a0++;
            if (ch_ack[1]) a1++;
            tick();
            if (a1 > 0) ch_req[1] = 1'b0;
        end
        n_checks++; if (a1 !== 1) begin n_fail++; $display("FAIL tf_write_granted: got %0d acks want 1", a1); end
        n_checks++; if (a0 !== 0) begin n_fail++; $display("FAIL tf_read_blocked: got %0d acks want 0", a0); end
        rd_valid_in = 1'b1;
        rd_data_in  = 128'h99;
        tick();
        rd_valid_in = 1'b0;
        @(negedge clk);
        n_checks++; if (ch_rd_valid !== 4'b0001) begin n_fail++; $display("FAIL tf_return: got %b want 0001", ch_rd_valid); end
        n_checks++; if (rd_outstanding !== 4'd7) begin n_fail++; $display("FAIL tf_outst7: got %0d want 7", rd_outstanding); end
        wait_ack(0, 10, seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL tf_ninth_read: no ack for ch0, ack %b", ch_ack); end
        tick();
        ch_req[0] = 1'b0;
        @(negedge clk);
        n_checks++; if (rd_outstanding !== 4'd8) begin n_fail++; $display("FAIL tf_refill: got %0d want 8", rd_outstanding); end
    endtask

    task automatic test_err_reset();
        bit seen;
        do_reset();
        rd_valid_in = 1'b1;
        rd_data_in  = 128'h55;
        tick();
        rd_valid_in = 1'b0;
        @(negedge clk);
        n_checks++; if (err_rd !== 1'b1) begin n_fail++; $display("FAIL er_set: got %b want 1", err_rd); end
        n_checks++; if (ch_rd_valid !== 4'b0000) begin n_fail++; $display("FAIL er_dropped: got %b want 0000", ch_rd_valid); end
        tick();
        tick();
        @(negedge clk);
        n_checks++; if (err_rd !== 1'b1) begin n_fail++; $display("FAIL er_sticky: got %b want 1", err_rd); end
        tick();
        set_ch(1, 1'b1, 1'b0, 26'h10, 3'd1, '0);
        wait_ack(1, 6, seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL er_ch1_read: no ack, ack %b", ch_ack); end
        tick();
        ch_req[1] = 1'b0;
        ready = 1'b0;
        set_ch(2, 1'b1, 1'b1, 26'h200, 3'd4, 128'hA0);
        tick();
        @(negedge clk);
        n_checks++; if (write_req !== 1'b1) begin n_fail++; $display("FAIL er_write_started: got %b want 1", write_req); end
        ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (write_req !== 1'b0) begin n_fail++; $display("FAIL er_async_wreq: got %b want 0", write_req); end
        n_checks++; if (burstbegin !== 1'b0) begin n_fail++; $display("FAIL er_async_bb: got %b want 0", burstbegin); end
        n_checks++; if (ch_ack !== 4'b0000) begin n_fail++; $display("FAIL er_async_ack: got %b want 0000", ch_ack); end
        n_checks++; if (avl_wr_data !== '0) begin n_fail++; $display("FAIL er_async_wdata: got %h want 0", avl_wr_data); end
        n_checks++; if (rd_outstanding !== 4'd0) begin n_fail++; $display("FAIL er_async_outst: got %0d want 0", rd_outstanding); end
        n_checks++; if (err_rd !== 1'b0) begin n_fail++; $display("FAIL er_async_err: got %b want 0", err_rd); end
        ch_req = '0;
        set_ch(0, 1'b1, 1'b0, 26'h1, 3'd1, '0);
        set_ch(3, 1'b1, 1'b0, 26'h3, 3'd1, '0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            @(negedge clk);
            if (ch_ack != 4'b0) seen = 1'b1;
        end
        n_checks++; if (ch_ack !== 4'b0001) begin n_fail++; $display("FAIL er_rr_restart: got %b want 0001", ch_ack); end
        ch_req = '0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_backpressure();
        test_interleaved();
        test_tag_full();
        test_err_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
